rv32i_mc_control: RTL

- Multi-cycle RV32I control sequencer. It is the initiator side of the ALU interface: it drives `ALUOp` and the operand-select muxes that feed the ALU `A`/`B` ports.
- It also drives the PC, IR, register-file and memory strobes.
- It sits between the instruction register and the single shared ALU of the multi-cycle datapath. It sequences each instruction through FETCH/DECODE/EXECUTE/MEM/WB.

---
 rtl/rv32i_mc_control_if.sv | 33 +++
 rtl/rv32i_mc_control.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/rv32i_mc_control_if.sv
// Control-sequencer <-> datapath bundle: IR/ALU status in, mux selects and strobes out.
interface rv32i_mc_control_if;
  logic [31:0] instr;
  logic        mem_rdata_valid;
  logic        alu_zero;
  logic        alu_lsb;
  logic [3:0]  ALUOp;
  logic [1:0]  alu_src_a;
  logic [1:0]  alu_src_b;
  logic [2:0]  imm_sel;
  logic        pc_we;
  logic        oldpc_we;
  logic        ir_we;
  logic        mem_re;
  logic        mem_we;
  logic        mem_addr_sel;
  logic        reg_we;
  logic [1:0]  wb_sel;
  logic        illegal;
  logic [2:0]  state;

  modport master (
    input  instr, mem_rdata_valid, alu_zero, alu_lsb,
    output ALUOp, alu_src_a, alu_src_b, imm_sel, pc_we, oldpc_we, ir_we,
           mem_re, mem_we, mem_addr_sel, reg_we, wb_sel, illegal, state
  );

  modport slave (
    output instr, mem_rdata_valid, alu_zero, alu_lsb,
    input  ALUOp, alu_src_a, alu_src_b, imm_sel, pc_we, oldpc_we, ir_we,
           mem_re, mem_we, mem_addr_sel, reg_we, wb_sel, illegal, state
  );
endinterface

// File: rtl/rv32i_mc_control.sv
// Multi-cycle RV32I control sequencer: steps each instruction through
// FETCH/DECODE/EXEC/MEM/WB/BR and drives the shared-ALU muxes and strobes.
module rv32i_mc_control #(
  parameter logic [2:0] RESET_STATE = 3'd0
) (
  input logic               clk,
  input logic               rst,
  rv32i_mc_control_if.master bus
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    BR     = 3'd5,
    TRAP   = 3'd7
  } state_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD    = 4'b0000;
  localparam logic [3:0] ALU_SUB    = 4'b1000;
  localparam logic [3:0] ALU_SLT    = 4'b0010;
  localparam logic [3:0] ALU_SLTU   = 4'b0011;
  localparam logic [3:0] ALU_PASS_B = 4'b1001;

  state_e     state_q, state_d;
  logic       take_q, take_d;
  logic       illegal_q, illegal_d;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [4:0] rd;
  logic       legal;
  logic       unused_instr_bits;

  assign opcode            = bus.instr[6:0];
  assign rd                = bus.instr[11:7];
  assign funct3            = bus.instr[14:12];
  assign unused_instr_bits = ^{bus.instr[31], bus.instr[29:15]};

  always_comb begin
    case (opcode)
      OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH,
      OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: legal = 1'b1;
      default:                           legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= state_e'(RESET_STATE);
      take_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      take_q    <= take_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d = state_q;
    take_d  = take_q;
    case (state_q)
      FETCH:  if (bus.mem_rdata_valid) state_d = DECODE;
      DECODE: state_d = legal ? EXEC : TRAP;
      EXEC: begin
        case (opcode)
          OP_LOAD, OP_STORE: state_d = MEM;
          OP_BRANCH: begin
            // funct3[2] picks the compare flag, funct3[0] inverts it
            take_d  = funct3[2] ? (bus.alu_lsb ^ funct3[0]) : (bus.alu_zero ^ funct3[0]);
            state_d = (funct3[2:1] == 2'b01) ? TRAP : BR;
          end
          default: state_d = WB;
        endcase
      end
      MEM:     if (bus.mem_rdata_valid) state_d = (opcode == OP_LOAD) ? WB : FETCH;
      WB, BR:  state_d = FETCH;
      TRAP:    state_d = TRAP;
      default: state_d = FETCH;
    endcase
    illegal_d = illegal_q | (state_d == TRAP);
  end

  always_comb begin
    bus.ALUOp        = ALU_ADD;
    bus.alu_src_a    = 2'd0;
    bus.alu_src_b    = 2'd0;
    bus.imm_sel      = 3'd0;
    bus.pc_we        = 1'b0;
    bus.oldpc_we     = 1'b0;
    bus.ir_we        = 1'b0;
    bus.mem_re       = 1'b0;
    bus.mem_we       = 1'b0;
    bus.mem_addr_sel = 1'b0;
    bus.reg_we       = 1'b0;
    bus.wb_sel       = 2'd0;
    bus.illegal      = illegal_q;
    bus.state        = state_q;
    case (state_q)
      FETCH: begin
        bus.mem_re    = 1'b1;
        bus.alu_src_a = 2'd1;
        bus.alu_src_b = 2'd2;
        bus.ir_we     = bus.mem_rdata_valid;
        bus.pc_we     = bus.mem_rdata_valid;
        bus.oldpc_we  = bus.mem_rdata_valid;
      end
      EXEC: begin
        case (opcode)
          OP_R: bus.ALUOp = {bus.instr[30], funct3};
          OP_IMM: begin
            bus.ALUOp     = (funct3 == 3'b101) ? {bus.instr[30], funct3} : {1'b0, funct3};
            bus.alu_src_b = 2'd1;
          end
          OP_LOAD:  bus.alu_src_b = 2'd1;
          OP_STORE: begin
            bus.alu_src_b = 2'd1;
            bus.imm_sel   = 3'd1;
          end
          OP_LUI: begin
            bus.ALUOp     = ALU_PASS_B;
            bus.alu_src_b = 2'd1;
            bus.imm_sel   = 3'd3;
          end
          OP_AUIPC: begin
            bus.alu_src_a = 2'd2;
            bus.alu_src_b = 2'd1;
            bus.imm_sel   = 3'd3;
          end
          OP_JAL: begin
            bus.alu_src_a = 2'd2;
            bus.alu_src_b = 2'd1;
            bus.imm_sel   = 3'd4;
            bus.pc_we     = 1'b1;
          end
          OP_JALR: begin
            bus.alu_src_b = 2'd1;
            bus.pc_we     = 1'b1;
          end
          OP_BRANCH: begin
            case (funct3[2:1])
              2'b10:   bus.ALUOp = ALU_SLT;
              2'b11:   bus.ALUOp = ALU_SLTU;
              default: bus.ALUOp = ALU_SUB;
            endcase
          end
          default: bus.ALUOp = ALU_ADD;
        endcase
      end
      MEM: begin
        bus.mem_addr_sel = 1'b1;
        bus.mem_re       = (opcode == OP_LOAD);
        bus.mem_we       = (opcode != OP_LOAD);
      end
      WB: begin
        bus.reg_we = (rd != 5'd0);
        if (opcode == OP_LOAD)                          bus.wb_sel = 2'd1;
        else if (opcode == OP_JAL || opcode == OP_JALR) bus.wb_sel = 2'd2;
      end
      BR: begin
        bus.alu_src_a = 2'd2;
        bus.alu_src_b = 2'd1;
        bus.imm_sel   = 3'd2;
        bus.pc_we     = take_q;
      end
      default: ;
    endcase
  end

endmodule
